// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG seven-segment digits sharing one decoder.
// Walks digits 0..NDIG-1 with optional all-dark guard cycles between slots, applies
// per-digit and leading-zero blanking, and swaps in new values only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DWELL = 16,
    parameter int GUARD = 2,
    parameter int LZB   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [4*NDIG-1:0]      value,
    input  logic [NDIG-1:0]        blank_mask,
    output logic [3:0]             hex,
    output logic [NDIG-1:0]        digit_en,
    output logic                   frame_done,
    output logic                   pending
);

    localparam int CMAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;
    localparam int IW   = $clog2(NDIG);

    localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GLAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);

    typedef enum logic {ST_GUARD, ST_SHOW} state_t;

    // With no guard cycles the scanner lives permanently in SHOW.
    localparam state_t ST_INIT  = (GUARD > 0) ? ST_GUARD : ST_SHOW;
    localparam state_t ST_AFTER = (GUARD > 0) ? ST_GUARD : ST_SHOW;

    state_t              state, nstate;
    logic [IW-1:0]       idx, nidx;
    logic [CW-1:0]       cnt, ncnt;
    logic [4*NDIG-1:0]   shadow, active, nactive;
    logic [NDIG-1:0]     shadow_mask, active_mask, nmask;
    logic                wrap, npend, nblank;

    // Digit i is dark when masked, or (with LZB) when it and every higher nibble are zero.
    // Digit 0 is never zero-blanked so an all-zero value still shows a single "0".
    function automatic logic is_blank(input logic [4*NDIG-1:0] v,
                                      input logic [NDIG-1:0]   m,
                                      input logic [IW-1:0]     i);
        logic z;
        logic b;
        z = 1'b1;
        b = m[i];
        for (int k = NDIG - 1; k >= 1; k--) begin
            z = z & (v[4*k +: 4] == 4'h0);
            if ((LZB != 0) && (k == int'(i)) && z)
                b = 1'b1;
        end
        return b;
    endfunction

    // Next-state decode: slot sequencing, frame-boundary buffer swap and load capture.
    always_comb begin
        nstate = state;
        nidx   = idx;
        ncnt   = cnt + CW'(1);
        wrap   = (state == ST_SHOW) && (idx == ILAST) && (cnt == DLAST);
        case (state)
            ST_GUARD: begin
                if (cnt == GLAST) begin
                    nstate = ST_SHOW;
                    ncnt   = '0;
                end
            end
            default: begin
                if (cnt == DLAST) begin
                    nstate = ST_AFTER;
                    ncnt   = '0;
                    nidx   = (idx == ILAST) ? '0 : idx + IW'(1);
                end
            end
        endcase
        nactive = (wrap && pending) ? shadow      : active;
        nmask   = (wrap && pending) ? shadow_mask : active_mask;
        // A load on the wrap edge lands in shadow after the old shadow was promoted.
        npend   = load ? 1'b1 : (wrap ? 1'b0 : pending);
        nblank  = is_blank(nactive, nmask, nidx);
    end

    // Scan FSM with registered outputs derived from the next state, so no input reaches an output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            idx         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            shadow_mask <= '0;
            active      <= '0;
            active_mask <= '0;
            pending     <= 1'b0;
            hex         <= 4'h0;
            digit_en    <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= nstate;
            idx         <= nidx;
            cnt         <= ncnt;
            active      <= nactive;
            active_mask <= nmask;
            pending     <= npend;
            if (load) begin
                shadow      <= value;
                shadow_mask <= blank_mask;
            end
            if (nstate == ST_SHOW) begin
                hex      <= nactive[4*nidx +: 4];
                digit_en <= nblank ? '0 : (NDIG'(1) << nidx);
            end else begin
                digit_en <= '0;
            end
            frame_done <= (nstate == ST_SHOW) && (nidx == ILAST) && (ncnt == DLAST);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random loads, every cycle checked
// against a frame-position model (cycle count mod frame length) of the display.
module tb_seg7_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DWELL = 4;
    localparam int GUARD = 1;
    localparam int SLOT  = GUARD + DWELL;
    localparam int FRAME = NDIG * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  hex, hex_n;
    logic [3:0]  digit_en, en_n;
    logic        frame_done, fd_n, pending, pend_n;

    seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD), .LZB(1)) u_dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .hex(hex), .digit_en(digit_en), .frame_done(frame_done), .pending(pending)
    );

    seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD), .LZB(0)) u_nolzb (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .hex(hex_n), .digit_en(en_n), .frame_done(fd_n), .pending(pend_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: cycles since reset release plus the two value buffers.
    int          c;
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_smask, m_amask, m_lasthex;
    logic        m_pend;

    function automatic logic [3:0] m_en(input bit lzb);
        int pos, slot;
        pos  = c % FRAME;
        slot = pos / SLOT;
        if ((pos % SLOT) < GUARD) return 4'b0;
        if (m_amask[slot]) return 4'b0;
        if (lzb && slot != 0 && (m_active >> (4 * slot)) == 16'h0) return 4'b0;
        return 4'(1 << slot);
    endfunction

    task automatic model_clear();
        c = 0; m_shadow = '0; m_active = '0; m_smask = '0; m_amask = '0;
        m_lasthex = '0; m_pend = 1'b0;
    endtask

    // One cycle: check outputs (at negedge), drive inputs, clock, advance model.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] bm);
        int pos, slot;
        logic [3:0] ehex;
        pos  = c % FRAME;
        slot = pos / SLOT;
        if ((pos % SLOT) >= GUARD) begin
            ehex      = m_active[4*slot +: 4];
            m_lasthex = ehex;
        end else begin
            ehex = m_lasthex;
        end
        chk("digit_en",       32'(digit_en),   32'(m_en(1'b1)));
        chk("digit_en_nolzb", 32'(en_n),       32'(m_en(1'b0)));
        chk("hex",            32'(hex),        32'(ehex));
        chk("hex_nolzb",      32'(hex_n),      32'(ehex));
        chk("frame_done",     32'(frame_done), 32'(pos == FRAME - 1));
        chk("pending",        32'(pending),    32'(m_pend));
        load = ld; value = v; blank_mask = bm;
        @(posedge clk);
        if (pos == FRAME - 1 && m_pend) begin
            m_active = m_shadow; m_amask = m_smask; m_pend = 1'b0;
        end
        if (ld) begin
            m_shadow = v; m_smask = bm; m_pend = 1'b1;
        end
        c++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME && (c % FRAME) != p; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    // Reset asserted mid-cycle: outputs must clear without a clock edge.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_digit_en", 32'(digit_en), 32'h0);
        chk("rst_hex",      32'(hex),      32'h0);
        chk("rst_pending",  32'(pending),  32'h0);
        chk("rst_fd",       32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [15:0] rv;
        int nz;
        model_clear();
        #2;
        chk("init_digit_en", 32'(digit_en), 32'h0);
        chk("init_hex",      32'(hex),      32'h0);
        chk("init_pending",  32'(pending),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // basic display of 1234
        step(1'b1, 16'h1234, 4'h0);
        idle(2 * FRAME);
        // leading-zero cases
        step(1'b1, 16'h0050, 4'h0);
        idle(2 * FRAME);
        step(1'b1, 16'h0000, 4'h0);
        idle(2 * FRAME);
        // load mid-frame during digit1 SHOW must not tear
        step(1'b1, 16'h1234, 4'h0);
        idle(2 * FRAME);
        run_to(SLOT + GUARD + 1);
        step(1'b1, 16'hABCD, 4'h0);
        idle(2 * FRAME);
        // load on the wrap edge with a load already pending
        run_to(3);
        step(1'b1, 16'h1111, 4'h0);
        run_to(FRAME - 1);
        step(1'b1, 16'h5555, 4'h0);
        idle(2 * FRAME);
        // reset in the middle of digit2 SHOW
        run_to(2 * SLOT + GUARD + 1);
        mid_reset();
        idle(FRAME + 2);
        // per-digit mask
        step(1'b1, 16'h1234, 4'b0100);
        idle(2 * FRAME);

        // random loads with frequent leading zeros and occasional masks
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rv = 16'($urandom);
                nz = $urandom_range(0, 4);
                rv = rv & (16'hFFFF >> (4 * nz));
                step(1'b1, rv, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            end else begin
                step(1'b0, 16'h0, 4'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
